// File: rtl/jtag_multi_driver_if.sv
// Bundle of command, response and JTAG pin signals for jtag_multi_driver.
// The slave modport is the driver engine; the master modport is the host and target side.
interface jtag_multi_driver_if #(
  parameter int NumChannels = 2,
  parameter int DataWidth   = 64,
  parameter int ClkDivWidth = 8
);
  localparam int ChanWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int LenWidth  = $clog2(DataWidth + 1);

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [ChanWidth-1:0]   cmd_chan_i;
  logic [1:0]             cmd_mode_i;
  logic [LenWidth-1:0]    cmd_len_i;
  logic                   cmd_exit_i;
  logic [DataWidth-1:0]   cmd_data_i;
  logic [ClkDivWidth-1:0] clk_div_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [DataWidth-1:0]   rsp_data_o;
  logic                   rsp_err_o;

  logic [NumChannels-1:0] jtag_tck_o;
  logic [NumChannels-1:0] jtag_tms_o;
  logic [NumChannels-1:0] jtag_tdi_o;
  logic [NumChannels-1:0] jtag_trst_no;
  logic [NumChannels-1:0] jtag_tdo_i;

  modport slave (
    input  cmd_valid_i, cmd_chan_i, cmd_mode_i, cmd_len_i, cmd_exit_i, cmd_data_i, clk_div_i,
    input  rsp_ready_i, jtag_tdo_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no
  );

  modport master (
    output cmd_valid_i, cmd_chan_i, cmd_mode_i, cmd_len_i, cmd_exit_i, cmd_data_i, clk_div_i,
    output rsp_ready_i, jtag_tdo_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no
  );
endinterface

// File: rtl/jtag_multi_driver.sv
// Multi-channel JTAG bit-bang engine: TMS sequences, TDI/TDO data shifts and TRST pulses.
// Define JTAG_DRV_TDO_SYNC_EN to resynchronise TDO and sample it at the end of the TCK high phase.
module jtag_multi_driver #(
  parameter int NumChannels = 2,
  parameter int DataWidth   = 64,
  parameter int ClkDivWidth = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  jtag_multi_driver_if.slave bus
);
  localparam int ChanWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int ChanLimitW = ChanWidth + 1;
  localparam int LenWidth   = $clog2(DataWidth + 1);
  localparam logic [LenWidth-1:0]   MaxLen    = LenWidth'(DataWidth);
  localparam logic [ChanLimitW-1:0] ChanLimit = ChanLimitW'(NumChannels);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RSP} state_t;

  state_t                 state;
  logic [NumChannels-1:0] chan_oh_q;
  logic [1:0]             mode_q;
  logic [LenWidth-1:0]    len_q;
  logic                   exit_q;
  logic [DataWidth-1:0]   data_q;
  logic [ClkDivWidth-1:0] div_q;
  logic [ClkDivWidth-1:0] phase_cnt;
  logic [LenWidth-1:0]    bit_cnt;

  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [DataWidth-1:0]   rsp_data_q;
  logic [NumChannels-1:0] tck_q;
  logic [NumChannels-1:0] tms_q;
  logic [NumChannels-1:0] tdi_q;
  logic [NumChannels-1:0] trst_n_q;

  logic                   accept;
  logic                   cmd_bad;
  logic                   last_bit;
  logic                   tdo_bit;
  logic                   capture_now;

  logic [NumChannels-1:0] nxt_chan_oh;
  logic [1:0]             nxt_mode;
  logic                   nxt_exit;
  logic [LenWidth-1:0]    nxt_len;
  logic [LenWidth-1:0]    nxt_idx;
  logic [DataWidth-1:0]   nxt_data;
  logic                   nxt_bit;
  logic                   nxt_tms;
  logic                   nxt_tdi;
  logic                   nxt_trst_n;
  logic [NumChannels-1:0] nxt_tms_vec;
  logic [NumChannels-1:0] nxt_tdi_vec;
  logic [NumChannels-1:0] nxt_trst_n_vec;

  assign accept   = bus.cmd_valid_i & cmd_ready_q;
  assign last_bit = (bit_cnt == len_q - LenWidth'(1));

  always_comb begin
    cmd_bad = (bus.cmd_mode_i == 2'd3) ||
              (bus.cmd_len_i > MaxLen) ||
              ({1'b0, bus.cmd_chan_i} >= ChanLimit);
`ifdef JTAG_DRV_TDO_SYNC_EN
    if (bus.clk_div_i < ClkDivWidth'(2)) cmd_bad = 1'b1;
`endif
  end

  // Pin values for the next LOW phase: bit 0 of the incoming command, or bit k+1 of the latched one.
  always_comb begin
    nxt_chan_oh = chan_oh_q;
    nxt_mode    = mode_q;
    nxt_exit    = exit_q;
    nxt_len     = len_q;
    nxt_data    = data_q;
    nxt_idx     = bit_cnt + LenWidth'(1);
    if (state == IDLE) begin
      nxt_chan_oh = NumChannels'(1) << bus.cmd_chan_i;
      nxt_mode    = bus.cmd_mode_i;
      nxt_exit    = bus.cmd_exit_i;
      nxt_len     = bus.cmd_len_i;
      nxt_data    = bus.cmd_data_i;
      nxt_idx     = '0;
    end
    nxt_bit    = |(nxt_data & (DataWidth'(1) << nxt_idx));
    nxt_tms    = 1'b0;
    nxt_tdi    = 1'b0;
    nxt_trst_n = 1'b1;
    case (nxt_mode)
      2'd0: nxt_tms = nxt_bit;
      2'd1: begin
        nxt_tdi = nxt_bit;
        nxt_tms = nxt_exit && (nxt_idx == nxt_len - LenWidth'(1));
      end
      2'd2: begin
        nxt_tms    = 1'b1;
        nxt_trst_n = 1'b0;
      end
      default: ;
    endcase
    nxt_tms_vec    = nxt_chan_oh & {NumChannels{nxt_tms}};
    nxt_tdi_vec    = nxt_chan_oh & {NumChannels{nxt_tdi}};
    nxt_trst_n_vec = ~(nxt_chan_oh & {NumChannels{~nxt_trst_n}});
  end

`ifdef JTAG_DRV_TDO_SYNC_EN
  logic [NumChannels-1:0] tdo_meta;
  logic [NumChannels-1:0] tdo_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdo_meta <= '0;
      tdo_sync <= '0;
    end else begin
      tdo_meta <= bus.jtag_tdo_i;
      tdo_sync <= tdo_meta;
    end
  end

  assign tdo_bit     = |(tdo_sync & chan_oh_q);
  assign capture_now = (state == HIGH) && (phase_cnt == '0);
`else
  // Raw TDO is taken on the same clock edge that raises TCK.
  assign tdo_bit     = |(bus.jtag_tdo_i & chan_oh_q);
  assign capture_now = (state == LOW) && (phase_cnt == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      chan_oh_q   <= '0;
      mode_q      <= '0;
      len_q       <= '0;
      exit_q      <= 1'b0;
      data_q      <= '0;
      div_q       <= '0;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      tck_q       <= '0;
      tms_q       <= '0;
      tdi_q       <= '0;
      trst_n_q    <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            chan_oh_q   <= nxt_chan_oh;
            mode_q      <= bus.cmd_mode_i;
            len_q       <= bus.cmd_len_i;
            exit_q      <= bus.cmd_exit_i;
            data_q      <= bus.cmd_data_i;
            div_q       <= bus.clk_div_i;
            phase_cnt   <= bus.clk_div_i;
            bit_cnt     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= cmd_bad;
            if (cmd_bad || (bus.cmd_len_i == '0)) begin
              state <= RSP;
            end else begin
              state    <= LOW;
              tck_q    <= '0;
              tms_q    <= nxt_tms_vec;
              tdi_q    <= nxt_tdi_vec;
              trst_n_q <= nxt_trst_n_vec;
            end
          end
        end
        LOW: begin
          if (phase_cnt == '0) begin
            phase_cnt <= div_q;
            state     <= HIGH;
            tck_q     <= (mode_q == 2'd2) ? '0 : chan_oh_q;
          end else begin
            phase_cnt <= phase_cnt - ClkDivWidth'(1);
          end
        end
        HIGH: begin
          if (phase_cnt == '0) begin
            phase_cnt <= div_q;
            tck_q     <= '0;
            if (last_bit) begin
              state    <= RSP;
              tms_q    <= '0;
              tdi_q    <= '0;
              trst_n_q <= '1;
            end else begin
              state    <= LOW;
              bit_cnt  <= bit_cnt + LenWidth'(1);
              tms_q    <= nxt_tms_vec;
              tdi_q    <= nxt_tdi_vec;
              trst_n_q <= nxt_trst_n_vec;
            end
          end else begin
            phase_cnt <= phase_cnt - ClkDivWidth'(1);
          end
        end
        RSP: begin
          // One settling cycle after the last HIGH phase before the response is offered.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture_now && (mode_q != 2'd2)) begin
        rsp_data_q <= rsp_data_q | (DataWidth'(tdo_bit) << bit_cnt);
      end
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.jtag_tck_o   = tck_q;
  assign bus.jtag_tms_o   = tms_q;
  assign bus.jtag_tdi_o   = tdi_q;
  assign bus.jtag_trst_no = trst_n_q;

endmodule

// File: tb/tb_jtag_multi_driver.sv
// Testbench for jtag_multi_driver: table of command vectors with TDO looped back to TDI,
// a response scoreboard, and hand-written back-pressure and mid-shift reset sequences.
module tb_jtag_multi_driver;
  localparam int NumChannels = 2;
  localparam int DataWidth   = 64;
  localparam int ClkDivWidth = 8;

  typedef struct {
    logic [1:0]  mode;
    logic        chan;
    logic [6:0]  len;
    logic        exit_bit;
    logic [63:0] data;
    logic [7:0]  div;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_lat;
    int          exp_rises;
    int          exp_trst_low;
    logic [63:0] exp_tms;
  } vec_t;

  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   vec_count = 0;
  int   miscompares = 0;
  exp_t sb[$];
  vec_t vecs[10];

  logic        mon_chan = 1'b0;
  int          rises_sel = 0;
  int          high_sel = 0;
  int          trst_low = 0;
  int          other_busy = 0;
  logic [63:0] tms_pat = '0;
  logic [1:0]  tck_prev = '0;

  jtag_multi_driver_if #(.NumChannels(NumChannels), .DataWidth(DataWidth), .ClkDivWidth(ClkDivWidth)) bus();

  jtag_multi_driver #(.NumChannels(NumChannels), .DataWidth(DataWidth), .ClkDivWidth(ClkDivWidth)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  assign bus.jtag_tdo_i = bus.jtag_tdi_o;

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic err, input logic [63:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic clear_mon(input logic chan);
    mon_chan   = chan;
    rises_sel  = 0;
    high_sel   = 0;
    trst_low   = 0;
    other_busy = 0;
    tms_pat    = '0;
  endtask

  task automatic drive_cmd(input logic [1:0] mode, input logic chan, input logic [6:0] len,
                           input logic exit_bit, input logic [63:0] data, input logic [7:0] div);
    bus.cmd_mode_i = mode;
    bus.cmd_chan_i = chan;
    bus.cmd_len_i  = len;
    bus.cmd_exit_i = exit_bit;
    bus.cmd_data_i = data;
    bus.clk_div_i  = div;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid_o && lat < 3000) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  // Pin monitor, sampled on the falling edge while the registered pins are stable.
  always @(negedge clk_i) begin
    for (int ch = 0; ch < NumChannels; ch++) begin
      if (ch == int'(mon_chan)) begin
        if (bus.jtag_tck_o[ch] && !tck_prev[ch]) begin
          tms_pat = tms_pat | (64'(bus.jtag_tms_o[ch]) << rises_sel);
          rises_sel++;
        end
        if (bus.jtag_tck_o[ch]) high_sel++;
        if (!bus.jtag_trst_no[ch]) trst_low++;
      end else if (bus.jtag_tck_o[ch] || bus.jtag_tms_o[ch] || bus.jtag_tdi_o[ch] || !bus.jtag_trst_no[ch]) begin
        other_busy++;
      end
    end
    tck_prev = bus.jtag_tck_o;
  end

  // Scoreboard consumer: every completed response handshake pops one expectation.
  always @(negedge clk_i) begin : rsp_checker
    exp_t e;
    if (!rst_i && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (sb.size() == 0) begin
        vec_count++;
        miscompares++;
        $display("[TB] FAIL unexpected_rsp: got response data 0x%0h, expected no response", bus.rsp_data_o);
      end else begin
        e = sb.pop_front();
        check_output("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
        check_output("rsp_data", bus.rsp_data_o, e.data);
      end
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int lat;
    int guard;
    @(negedge clk_i);
    drive_cmd(v.mode, v.chan, v.len, v.exit_bit, v.data, v.div);
    bus.cmd_valid_i = 1'b1;
    guard = 0;
    while (!bus.cmd_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check_output("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    bus.cmd_valid_i = 1'b0;
    clear_mon(v.chan);
    push_exp(v.exp_err, v.exp_data);
    wait_rsp(lat);
    check_output("latency", 64'(lat), 64'(v.exp_lat));
    check_output("tck_rises", 64'(rises_sel), 64'(v.exp_rises));
    check_output("tck_high_cycles", 64'(high_sel), 64'(v.exp_rises * (int'(v.div) + 1)));
    check_output("trst_low_cycles", 64'(trst_low), 64'(v.exp_trst_low));
    check_output("tms_at_rise", tms_pat, v.exp_tms);
    check_output("other_chan_idle", 64'(other_busy), 64'd0);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b0;
    check_output("rsp_valid_drop", 64'(bus.rsp_valid_o), 64'd0);
    check_output("cmd_ready_back", 64'(bus.cmd_ready_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int guard;
    int valid_seen;

    //        mode  ch    len    exit  data                    div     err   exp_data                lat  rise trst tms
    vecs[0] = '{2'd1, 1'b0, 7'd8,  1'b1, 64'hA5,                 8'd0,   1'b0, 64'hA5,                 17,  8,   0,   64'h80};
    vecs[1] = '{2'd0, 1'b1, 7'd5,  1'b0, 64'h1F,                 8'd3,   1'b0, 64'h0,                  41,  5,   0,   64'h1F};
    vecs[2] = '{2'd2, 1'b0, 7'd2,  1'b0, 64'h0,                  8'd1,   1'b0, 64'h0,                  9,   0,   8,   64'h0};
    vecs[3] = '{2'd1, 1'b0, 7'd65, 1'b0, 64'hFF,                 8'd0,   1'b1, 64'h0,                  1,   0,   0,   64'h0};
    vecs[4] = '{2'd3, 1'b1, 7'd4,  1'b0, 64'hFF,                 8'd0,   1'b1, 64'h0,                  1,   0,   0,   64'h0};
    vecs[5] = '{2'd1, 1'b0, 7'd0,  1'b1, 64'hFF,                 8'd2,   1'b0, 64'h0,                  1,   0,   0,   64'h0};
    vecs[6] = '{2'd1, 1'b1, 7'd64, 1'b0, 64'hDEADBEEF01234567,   8'd0,   1'b0, 64'hDEADBEEF01234567,   129, 64,  0,   64'h0};
    vecs[7] = '{2'd1, 1'b0, 7'd12, 1'b1, 64'hFFFFF3C,            8'd2,   1'b0, 64'hF3C,                73,  12,  0,   64'h800};
    vecs[8] = '{2'd1, 1'b1, 7'd1,  1'b1, 64'h1,                  8'd255, 1'b0, 64'h1,                  513, 1,   0,   64'h1};
    vecs[9] = '{2'd0, 1'b0, 7'd3,  1'b0, 64'h5,                  8'd0,   1'b0, 64'h0,                  7,   3,   0,   64'h5};

    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    drive_cmd(2'd0, 1'b0, 7'd0, 1'b0, 64'h0, 8'd0);

    #1 rst_i = 1'b1;
    #2;
    check_output("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_output("reset_rsp_data", bus.rsp_data_o, 64'd0);
    check_output("reset_rsp_err", 64'(bus.rsp_err_o), 64'd0);
    check_output("reset_tck", 64'(bus.jtag_tck_o), 64'd0);
    check_output("reset_tms", 64'(bus.jtag_tms_o), 64'd0);
    check_output("reset_tdi", 64'(bus.jtag_tdi_o), 64'd0);
    check_output("reset_trst_n", 64'(bus.jtag_trst_no), 64'd3);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_output("reset_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
    end

    // Back-pressure: response held for 10 cycles while a second command waits with valid high.
    @(negedge clk_i);
    drive_cmd(2'd1, 1'b0, 7'd4, 1'b0, 64'h9, 8'd0);
    bus.cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    push_exp(1'b0, 64'h9);
    clear_mon(1'b0);
    drive_cmd(2'd1, 1'b1, 7'd3, 1'b1, 64'h5, 8'd1);
    wait_rsp(lat);
    check_output("bp_latency", 64'(lat), 64'd9);
    repeat (10) begin
      @(negedge clk_i);
      check_output("bp_rsp_valid_hold", 64'(bus.rsp_valid_o), 64'd1);
      check_output("bp_cmd_ready_low", 64'(bus.cmd_ready_o), 64'd0);
      check_output("bp_rsp_data_hold", bus.rsp_data_o, 64'h9);
    end
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b0;
    check_output("bp_ready_after_hs", 64'(bus.cmd_ready_o), 64'd1);
    check_output("bp_valid_after_hs", 64'(bus.rsp_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    check_output("bp_second_accepted", 64'(bus.cmd_ready_o), 64'd0);
    bus.cmd_valid_i = 1'b0;
    push_exp(1'b0, 64'h5);
    clear_mon(1'b1);
    wait_rsp(lat);
    check_output("bp2_latency", 64'(lat), 64'd13);
    check_output("bp2_tck_rises", 64'(rises_sel), 64'd3);
    check_output("bp2_tms_at_rise", tms_pat, 64'h4);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b0;

    // Reset in the middle of bit 3 of a 16-bit shift: no response may follow.
    @(negedge clk_i);
    drive_cmd(2'd1, 1'b0, 7'd16, 1'b0, 64'hFFFF, 8'd1);
    bus.cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.cmd_valid_i = 1'b0;
    clear_mon(1'b0);
    guard = 0;
    while (rises_sel < 4 && guard < 200) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    check_output("abort_reached_bit3", 64'(rises_sel), 64'd4);
    check_output("abort_tck_before", 64'(bus.jtag_tck_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check_output("abort_tck", 64'(bus.jtag_tck_o), 64'd0);
    check_output("abort_tms", 64'(bus.jtag_tms_o), 64'd0);
    check_output("abort_tdi", 64'(bus.jtag_tdi_o), 64'd0);
    check_output("abort_trst_n", 64'(bus.jtag_trst_no), 64'd3);
    check_output("abort_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_output("abort_rsp_data", bus.rsp_data_o, 64'd0);
    check_output("abort_rsp_err", 64'(bus.rsp_err_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_output("abort_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    bus.rsp_ready_i = 1'b1;
    valid_seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o) valid_seen++;
    end
    bus.rsp_ready_i = 1'b0;
    check_output("abort_no_rsp", 64'(valid_seen), 64'd0);
    check_output("abort_pins_idle", 64'(rises_sel), 64'd4);

    check_output("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
